// File: rtl/display_scan_ctrl_if.sv
// Link between the display datapath and the digit scan controller:
// scan/blink controls in, digit-select timing out.
interface display_scan_ctrl_if;
   logic       en;
   logic       blink_en;
   logic [7:0] blink_mask;
   logic [7:0] SEL_digit;
   logic [2:0] digit_idx;
   logic       scan_tick;
   logic       frame_done;
   logic       blink_phase;

   modport master (
      output en, blink_en, blink_mask,
      input  SEL_digit, digit_idx, scan_tick, frame_done, blink_phase
   );

   modport slave (
      input  en, blink_en, blink_mask,
      output SEL_digit, digit_idx, scan_tick, frame_done, blink_phase
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Eight-digit seven-segment scan controller: active-low one-hot digit select,
// per-slot anti-ghosting blank interval and frame-rate blink of masked digits.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | en=0; counters parked at 0, all digits off
//   ST_BLANK | start of slot (cnt < BLANK_CYCLES); all digits off
//   ST_ON    | rest of slot; current digit driven unless blinked off
module display_scan_ctrl #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 50,
   parameter int BLINK_FRAMES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   display_scan_ctrl_if.slave bus
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_ON    = CW'(BLANK_CYCLES);
   localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BLANK,
      ST_ON
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic [7:0]    sel_q, sel_d;
   logic          scan_tick_q, scan_tick_d;
   logic          frame_done_q, frame_done_d;
   logic          slot_end;
   logic          frame_end;
   logic          blink_off;

   // Outputs are registered from next-state values so that they line up
   // with the counter cycle they describe.
   always_comb begin
      state_d       = ST_IDLE;
      cnt_d         = {CW{1'b0}};
      idx_d         = 3'd0;
      fcnt_d        = {FW{1'b0}};
      blink_phase_d = blink_phase_q;
      slot_end      = 1'b0;
      frame_end     = 1'b0;

      if (bus.en) begin
         if (state_q != ST_IDLE) begin
            slot_end  = (cnt_q == CNT_LAST);
            frame_end = slot_end && (idx_q == 3'd7);
            cnt_d     = slot_end ? {CW{1'b0}} : cnt_q + 1'b1;
            idx_d     = slot_end ? idx_q + 3'd1 : idx_q;
            fcnt_d    = fcnt_q;
            if (frame_end) begin
               if (fcnt_q == FCNT_LAST) begin
                  fcnt_d        = {FW{1'b0}};
                  blink_phase_d = ~blink_phase_q;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end

         if (cnt_d == {CW{1'b0}}) begin
            state_d = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
         end else if (cnt_d == CNT_ON) begin
            state_d = ST_ON;
         end else begin
            state_d = state_q;
         end
      end

      scan_tick_d  = (state_d != ST_IDLE) && (cnt_d == CNT_LAST);
      frame_done_d = scan_tick_d && (idx_d == 3'd7);
      blink_off    = bus.blink_en && blink_phase_d && bus.blink_mask[idx_d];
      sel_d        = ((state_d == ST_ON) && !blink_off) ? ~(8'h80 >> idx_d) : 8'hFF;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= {CW{1'b0}};
         idx_q         <= 3'd0;
         fcnt_q        <= {FW{1'b0}};
         blink_phase_q <= 1'b0;
         sel_q         <= 8'hFF;
         scan_tick_q   <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         fcnt_q        <= fcnt_d;
         blink_phase_q <= blink_phase_d;
         sel_q         <= sel_d;
         scan_tick_q   <= scan_tick_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign bus.SEL_digit   = sel_q;
   assign bus.digit_idx   = idx_q;
   assign bus.scan_tick   = scan_tick_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.blink_phase = blink_phase_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: a vector table for idle, scan and blink,
// then hand sequences for disable, async reset and a zero-blank instance.
module tb_display_scan_ctrl;

   localparam int SD = 4;
   localparam int BC = 1;
   localparam int BF = 2;
   localparam int NV = 148;

   typedef struct {
      logic       en;
      logic       blink_en;
      logic [7:0] mask;
      logic [7:0] sel;
      logic [2:0] idx;
      logic       tick;
      logic       fd;
      logic       ph;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   vec_t       vecs [NV];
   logic [7:0] codes [8];

   display_scan_ctrl_if bus  ();
   display_scan_ctrl_if bus0 ();

   display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(0), .BLINK_FRAMES(BF)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] sel, input logic [2:0] idx,
                        input logic tick, input logic fd, input logic ph);
      n_vec++;
      if (bus.SEL_digit !== sel || bus.digit_idx !== idx || bus.scan_tick !== tick ||
          bus.frame_done !== fd || bus.blink_phase !== ph) begin
         n_err++;
         $display("FAIL %s: got sel=%h idx=%0d tick=%b fd=%b ph=%b, want sel=%h idx=%0d tick=%b fd=%b ph=%b",
                  name, bus.SEL_digit, bus.digit_idx, bus.scan_tick, bus.frame_done, bus.blink_phase,
                  sel, idx, tick, fd, ph);
      end
   endtask

   task automatic check0(input string name, input logic [7:0] sel, input logic [2:0] idx,
                         input logic tick);
      n_vec++;
      if (bus0.SEL_digit !== sel || bus0.digit_idx !== idx || bus0.scan_tick !== tick ||
          $countones(~bus0.SEL_digit) != 1) begin
         n_err++;
         $display("FAIL %s: got sel=%h idx=%0d tick=%b, want sel=%h idx=%0d tick=%b (one bit low)",
                  name, bus0.SEL_digit, bus0.digit_idx, bus0.scan_tick, sel, idx, tick);
      end
   endtask

   initial begin
      codes[0] = 8'h7F; codes[1] = 8'hBF; codes[2] = 8'hDF; codes[3] = 8'hEF;
      codes[4] = 8'hF7; codes[5] = 8'hFB; codes[6] = 8'hFD; codes[7] = 8'hFE;

      // Idle vectors, then 4 frames of scan with blinking of digits 0 and 1;
      // blink_en is dropped for frame 3 while the phase is still 1.
      for (int i = 0; i < 20; i++) begin
         vecs[i].en = 1'b0; vecs[i].blink_en = 1'b0; vecs[i].mask = 8'h00;
         vecs[i].sel = 8'hFF; vecs[i].idx = 3'd0;
         vecs[i].tick = 1'b0; vecs[i].fd = 1'b0; vecs[i].ph = 1'b0;
      end
      for (int t = 0; t < 128; t++) begin
         int s, c, ph;
         logic be;
         s  = (t / 4) % 8;
         c  = t % 4;
         ph = (t / 64) % 2;
         be = (t < 96);
         vecs[20+t].en       = 1'b1;
         vecs[20+t].blink_en = be;
         vecs[20+t].mask     = 8'h03;
         vecs[20+t].idx      = 3'(s);
         vecs[20+t].tick     = (c == 3);
         vecs[20+t].fd       = (c == 3) && (s == 7);
         vecs[20+t].ph       = (ph == 1);
         if (c == 0 || (be && ph == 1 && s < 2))
            vecs[20+t].sel = 8'hFF;
         else
            vecs[20+t].sel = codes[s];
      end

      bus.en = 1'b0;  bus.blink_en = 1'b0;  bus.blink_mask = 8'h00;
      bus0.en = 1'b0; bus0.blink_en = 1'b0; bus0.blink_mask = 8'h00;

      #12;
      check("reset", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (bus0.SEL_digit !== 8'hFF || bus0.digit_idx !== 3'd0) begin
         n_err++;
         $display("FAIL reset0: got sel=%h idx=%0d, want sel=ff idx=0", bus0.SEL_digit, bus0.digit_idx);
      end
      #10 rst_n = 1'b1;
      step();

      for (int i = 0; i < NV; i++) begin
         bus.en         = vecs[i].en;
         bus.blink_en   = vecs[i].blink_en;
         bus.blink_mask = vecs[i].mask;
         step();
         check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].idx, vecs[i].tick, vecs[i].fd, vecs[i].ph);
         n_vec++;
         if ($countones(~bus.SEL_digit) > 1) begin
            n_err++;
            $display("FAIL onehot%0d: got sel=%h, want at most one bit low", i, bus.SEL_digit);
         end
      end

      // Run on to slot 5, cnt 2 of frame 6 (phase 1), then drop en mid-slot.
      for (int t = 128; t <= 214; t++) step();
      check("slot5_cnt2", 8'hFB, 3'd5, 1'b0, 1'b0, 1'b1);
      bus.en = 1'b0;
      step();
      check("disable", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step();
      check("idle_hold", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);

      bus.en = 1'b1;
      step();
      check("reen_blank", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
      step();
      check("reen_slot0", 8'h7F, 3'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 2; k <= 13; k++) begin
         step();
         if (k == 3) check("reen_tick", 8'h7F, 3'd0, 1'b1, 1'b0, 1'b1);
      end
      check("slot3_on", 8'hEF, 3'd3, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset between edges, released between edges with en=1.
      #2 rst_n = 1'b0;
      #1 check("async_rst", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      #1 check("rst_release", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
      check("post_rst_blank", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
      check("post_rst_slot0", 8'h7F, 3'd0, 1'b0, 1'b0, 1'b0);

      // Zero-blank instance: every enabled cycle drives exactly one digit.
      bus.en  = 1'b0;
      bus0.en = 1'b1;
      for (int t = 0; t < 70; t++) begin
         step();
         check0($sformatf("zb%0d", t), codes[(t / 4) % 8], 3'((t / 4) % 8), (t % 4) == 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
